// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator
// Sums per-byte popcounts (0..8) over a frame delimited by in_last and
// presents the frame total, beat count and status flags on a held
// valid/ready output. Optional alarm output is built when ONES_ALARM_EN
// is defined (adds ALARM_LEVEL parameter and alarm port).
module ones_frame_accumulator #(
   parameter int COUNT_W     = 12
`ifdef ONES_ALARM_EN
   ,
   parameter int ALARM_LEVEL = 64
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_count,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COUNT_W-1:0] out_total,
   output logic [7:0]         out_beats,
   output logic               out_sat,
   output logic               out_badcount
`ifdef ONES_ALARM_EN
   ,
   output logic               alarm
`endif
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [COUNT_W-1:0] TOTAL_MAX = '1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_in_ready;

   logic [COUNT_W-1:0]   r_total;
   logic [7:0]           r_beats;
   logic                 r_sat;
   logic                 r_bad;

   logic [COUNT_W-1:0]   r_out_total;
   logic [7:0]           r_out_beats;
   logic                 r_out_sat;
   logic                 r_out_bad;

   logic                 w_accept;
   logic                 w_accept_last;
   logic [3:0]           w_clamped;
   logic                 w_bad_beat;
   logic [COUNT_W:0]     w_sum;
   logic [COUNT_W-1:0]   w_total_nxt;
   logic [7:0]           w_beats_nxt;
   logic                 w_sat_nxt;
   logic                 w_bad_nxt;

   // in_ready is registered, so it is zero through reset and never depends
   // combinationally on out_ready.
   assign w_accept      = in_valid && r_in_ready;
   assign w_accept_last = w_accept && in_last;

   // Clamp illegal counts to 8; the sum carries one extra bit so that,
   // with TOTAL_MAX all ones, the carry bit alone flags overflow.
   assign w_bad_beat  = (in_count > 4'd8);
   assign w_clamped   = w_bad_beat ? 4'd8 : in_count;
   assign w_sum       = {1'b0, r_total} + {{(COUNT_W-3){1'b0}}, w_clamped};
   assign w_total_nxt = w_sum[COUNT_W] ? TOTAL_MAX : w_sum[COUNT_W-1:0];
   assign w_beats_nxt = (r_beats == 8'hFF) ? 8'hFF : r_beats + 8'd1;
   // A beat arriving with 255 already counted is the 256th: saturate.
   assign w_sat_nxt   = r_sat | w_sum[COUNT_W] | (r_beats == 8'hFF);
   assign w_bad_nxt   = r_bad | w_bad_beat;

   // Next-state decode: leave ACCUM on the last beat, leave HOLD on handshake.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM:   if (w_accept_last) w_state_nxt = HOLD;
         HOLD:    if (out_ready)     w_state_nxt = ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
   end

   // State register plus the registered ready decode of the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ACCUM;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt == ACCUM);
      end
   end

   // Running frame accumulators; cleared when the frame closes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_total <= '0;
         r_beats <= '0;
         r_sat   <= 1'b0;
         r_bad   <= 1'b0;
      end else if (w_accept) begin
         if (in_last) begin
            r_total <= '0;
            r_beats <= '0;
            r_sat   <= 1'b0;
            r_bad   <= 1'b0;
         end else begin
            r_total <= w_total_nxt;
            r_beats <= w_beats_nxt;
            r_sat   <= w_sat_nxt;
            r_bad   <= w_bad_nxt;
         end
      end
   end

   // Result registers capture the totals including the last beat and hold
   // through HOLD (no accepts can happen there).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_total <= '0;
         r_out_beats <= '0;
         r_out_sat   <= 1'b0;
         r_out_bad   <= 1'b0;
      end else if (w_accept_last) begin
         r_out_total <= w_total_nxt;
         r_out_beats <= w_beats_nxt;
         r_out_sat   <= w_sat_nxt;
         r_out_bad   <= w_bad_nxt;
      end
   end

`ifdef ONES_ALARM_EN
   logic r_fired;
   logic r_alarm;
   logic w_hit;

   assign w_hit = !r_fired && (32'(w_total_nxt) >= 32'(ALARM_LEVEL));

   // One-shot alarm per frame; re-armed when the frame closes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fired <= 1'b0;
         r_alarm <= 1'b0;
      end else begin
         r_alarm <= w_accept && w_hit;
         if (w_accept_last)
            r_fired <= 1'b0;
         else if (w_accept && w_hit)
            r_fired <= 1'b1;
      end
   end

   assign alarm = r_alarm;
`endif

   assign in_ready     = r_in_ready;
   assign out_valid    = (r_state == HOLD);
   assign out_total    = r_out_total;
   assign out_beats    = r_out_beats;
   assign out_sat      = r_out_sat;
   assign out_badcount = r_out_bad;

endmodule

// File: doc/ones_frame_accumulator.md
# ones_frame_accumulator

Sequential stage directly downstream of the `count_ones` popcount block. It consumes one per-byte ones count per beat over a valid/ready handshake and sums the counts across a frame delimited by `in_last`. It then presents the frame total, beat count and status flags on a held output handshake. Its typical use is to build per-packet ones statistics from the 8-bit popcount datapath.

## Interface
- `COUNT_W`, default 12: width of frame total; must be 4–16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_count`  in  4  ones count of one byte; legal range 0–8; driven from `count_ones.num_of_ones`.
- `in_last`  in  1  beat is the final beat of the frame.
- `out_valid`  out  1  frame result valid; held until accepted.
- `out_ready`  in  1  downstream accepts result.
- `out_total`  out  COUNT_W  saturating sum of `in_count` over the frame.
- `out_beats`  out  8  saturating number of beats in the frame.
- `out_sat`  out  1  `out_total` or `out_beats` saturated during the frame.
- `out_badcount`  out  1  at least one beat had `in_count` > 8.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- Accept condition: `in_valid && in_ready`.
- ACCUM:
  - `in_ready`=1.
  - On accept, clamp `in_count` to 8 if it exceeds 8 and set the running badcount flag.
  - Add the clamped value to the running total, saturating at 2^COUNT_W−1. Set the running sat flag if the true sum exceeds that value.
  - Increment the running beat count, saturating at 255. Set the running sat flag on the 256th beat.
- Accept with `in_last`=1:
  - Load `out_total`, `out_beats`, `out_sat` and `out_badcount` with the values that include this beat.
  - Set `out_valid`=1 and go to HOLD.
  - Clear the running total, beat count and flags.
- HOLD:
  - `in_ready`=0 and all outputs stable.
  - On `out_valid && out_ready`: drop `out_valid` and return to ACCUM.
- `in_valid` without accept in HOLD has no effect. Upstream must hold the beat.
- A single-beat frame (`in_last` on the first beat) is legal: total = clamped count, beats = 1.
- Zero-count beats are legal and increment beats only.
- All four status/data outputs are valid only while `out_valid`=1.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - `in_ready`=0 during reset cycles, 1 from the first cycle after release.
  - `out_valid`=0.
  - `out_total`=0, `out_beats`=0, `out_sat`=0, `out_badcount`=0.
  - Running state cleared.
- Reset mid-frame or in HOLD discards the partial frame or pending result. No output follows.
- `in_ready` is a decode of the registered state only, with no combinational path from `out_ready`.
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat, i.e. it is visible the cycle after that beat is presented.
- Throughput: one beat per cycle in ACCUM. An N-beat frame with `out_ready` tied high costs N+1 cycles; the extra cycle is HOLD.
- `out_ready` high in the first HOLD cycle completes the handshake on that edge, and ACCUM resumes the next cycle.
- Saturation and clamp happen in the same cycle as the accept. There is no wrap-around of the total or the beat count.

## Configuration
- `ONES_ALARM_EN` defined:
  - Adds parameter `ALARM_LEVEL`, default 64.
  - Adds output `alarm` (1 bit, reset 0).
  - `alarm` pulses high for exactly one cycle on the edge where the running total first becomes ≥ `ALARM_LEVEL` within a frame.
  - At most one pulse per frame, re-armed when the frame ends or on reset.
  - If the threshold is crossed on the `in_last` beat, the pulse coincides with `out_valid` rising.
- `ONES_ALARM_EN` undefined: neither `alarm` nor `ALARM_LEVEL` exists, and there is no alarm logic.

## Test plan
- Reset, then a frame of counts 0,1,3,4,5,5,8 (the popcounts of 00,01,07,55,D5,73,FF), last on the 7th, `out_ready`=1 → total=26, beats=7, sat=0, badcount=0; `out_valid` high for exactly 1 cycle.
- Single-beat frame, count 8 with last; `out_ready` held low 5 cycles → `out_valid` high and `in_ready`=0 for 5 cycles, total=8, beats=1; ACCUM resumes the cycle after `out_ready`=1.
- COUNT_W=4, frame of three beats of 8 → total=15, sat=1. Beat count of 256+ beats → `out_beats`=255, sat=1.
- Beat with `in_count`=12 in a 2-beat frame {12,2} → total=10, badcount=1; the next frame's badcount=0.
- Assert `rst_n`=0 for 1 cycle after 3 beats of a frame, then send frame {2,2 last} → total=4, beats=2, with no output from the aborted frame.
- With `ONES_ALARM_EN`, ALARM_LEVEL=10, frame {4,4,4,4 last} → one `alarm` pulse on the 3rd accept. Frame {8,2 last} → pulse coincident with `out_valid`.
